// File: rtl/music_player.sv
`default_nettype none
// ============================================================================
// Module   : music_player
// Purpose  : Steps a 64-entry note ROM one beat at a time and drives a square-wave buzzer.
//            Optional macro MUSIC_LOOP_EN: wrap to step 0 at end of score instead of stopping.
// Revision : 1.0 - initial release
// ============================================================================
module music_player #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BEAT_CYC = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [5:0] cnt_music,
  input  logic [7:0] key,
  output logic       buzzer,
  output logic       playing,
  output logic       done
);

  function automatic int f_hp(input int f);
    return CLK_HZ / (2 * f);
  endfunction

  localparam int c_HP_C4 = f_hp(262);
  localparam int c_TW    = $clog2(c_HP_C4 + 1);
  localparam int c_BW    = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  // Index order: C4..B4, C5, D5..B5
  localparam int c_HP [14] = '{
    f_hp(262), f_hp(294), f_hp(330), f_hp(349), f_hp(392), f_hp(440), f_hp(494),
    f_hp(523), f_hp(587), f_hp(659), f_hp(698), f_hp(784), f_hp(880), f_hp(988)
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_BW-1:0] r_beat;
  logic [5:0]      r_cnt;
  logic            r_load;
  logic            r_done;
  logic            r_phase;
  logic            r_buzzer;
  logic [c_TW-1:0] r_note;
  logic [c_TW-1:0] r_tone;
  logic [c_TW-1:0] w_note_nxt;
  logic [c_TW-1:0] w_tone_nxt;
  logic [c_TW-1:0] w_dec;
  logic            w_phase_nxt;
  logic            w_tc;
  logic            w_last;
  logic            w_load;

  // Returns the tone half-period for a key code; zero means rest.
  function automatic logic [c_TW-1:0] f_decode(input logic [7:0] k);
    logic [6:0] lo;
    lo       = ~k[6:0];
    f_decode = '0;
    if (k[7]) begin
      for (int n = 0; n < 7; n++)
        if (lo == 7'(1 << n)) f_decode = c_TW'(c_HP[n]);
    end else if (lo == 7'd0) begin
      f_decode = c_TW'(c_HP[7]);
    end else if (!lo[6]) begin
      for (int n = 0; n < 6; n++)
        if (lo[5:0] == 6'(1 << n)) f_decode = c_TW'(c_HP[n + 8]);
    end
  endfunction

  assign w_dec  = f_decode(key);
  assign w_tc   = (r_state == PLAY) && !stop && (r_beat == c_BW'(BEAT_CYC - 1));
  assign w_last = w_tc && (r_cnt == 6'd63);
  assign w_load = ((r_state == IDLE) && (w_state_nxt == PLAY)) ||
                  (r_load && (r_state != IDLE));

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start && !pause) w_state_nxt = PLAY;
        PLAY: begin
`ifdef MUSIC_LOOP_EN
          if (pause) w_state_nxt = PAUSE;
`else
          if (w_last)     w_state_nxt = IDLE;
          else if (pause) w_state_nxt = PAUSE;
`endif
        end
        PAUSE:   if (!pause) w_state_nxt = PLAY;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Beat counter and score position; PAUSE holds both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_cnt  <= '0;
      r_load <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_load <= w_tc;
      r_done <= w_last;
      if (stop) begin
        r_beat <= '0;
        r_cnt  <= '0;
      end else if (r_state == PLAY) begin
        if (w_tc) begin
          r_beat <= '0;
          r_cnt  <= r_cnt + 6'd1;
        end else begin
          r_beat <= r_beat + c_BW'(1);
        end
      end else if (r_state == IDLE) begin
        r_beat <= '0;
      end
    end
  end

  always_comb begin
    w_note_nxt  = r_note;
    w_tone_nxt  = r_tone;
    w_phase_nxt = r_phase;
    if (w_state_nxt == IDLE) begin
      w_note_nxt  = '0;
      w_tone_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (w_load) begin
      w_note_nxt  = w_dec;
      w_tone_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if ((r_state == PLAY) && (r_note != '0)) begin
      if (r_tone == r_note - c_TW'(1)) begin
        w_tone_nxt  = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_tone_nxt  = r_tone + c_TW'(1);
      end
    end
  end

  // r_phase keeps the tone phase across PAUSE while the pin itself is forced low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_note   <= '0;
      r_tone   <= '0;
      r_phase  <= 1'b0;
      r_buzzer <= 1'b0;
    end else begin
      r_note   <= w_note_nxt;
      r_tone   <= w_tone_nxt;
      r_phase  <= w_phase_nxt;
      r_buzzer <= w_phase_nxt && (w_state_nxt == PLAY);
    end
  end

  assign cnt_music = r_cnt;
  assign buzzer    = r_buzzer;
  assign done      = r_done;
  assign playing   = (r_state == PLAY);

endmodule
`default_nettype wire

// File: tb/tb_music_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_music_player
// Purpose  : Self-checking bench for music_player with scoreboarded buzzer edges and checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_music_player;
  localparam int CLK_HZ = 100_000;
  localparam int BEAT   = 600;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop  = 1'b0;
  logic [5:0] cnt_music;
  logic [7:0] key;
  logic       buzzer;
  logic       playing;
  logic       done;

  logic [7:0] rom [64];
  logic [7:0] fill [16] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
                            8'h7E, 8'h7D, 8'h7B, 8'h77, 8'h6F, 8'h5F, 8'h00, 8'hBE};
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {int cyc; logic v;} ev_t;
  typedef struct {int cyc; logic [5:0] cnt; logic chk_buz; logic buz; logic play; logic dn;} cp_t;
  ev_t ev_q[$];
  cp_t cp_q[$];

  assign key = rom[cnt_music];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  music_player #(.CLK_HZ(CLK_HZ), .BEAT_CYC(BEAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
    .cnt_music(cnt_music), .key(key), .buzzer(buzzer), .playing(playing), .done(done)
  );

  function automatic int exp_hp(input logic [7:0] k);
    int f;
    case (k)
      8'hFE: f = 262;  8'hFD: f = 294;  8'hFB: f = 330;  8'hF7: f = 349;
      8'hEF: f = 392;  8'hDF: f = 440;  8'hBF: f = 494;  8'h7F: f = 523;
      8'h7E: f = 587;  8'h7D: f = 659;  8'h7B: f = 698;  8'h77: f = 784;
      8'h6F: f = 880;  8'h5F: f = 988;
      default: f = 0;
    endcase
    return (f == 0) ? 0 : CLK_HZ / (2 * f);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cnt_music !== 6'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_music); end
    total++; if (buzzer !== 1'b0)    begin bad++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
    total++; if (playing !== 1'b0)   begin bad++; $display("FAIL reset_playing: got %b want 0", playing); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tone;
    int p0, e, ls, le, hp;
    logic b, lastb;
    ev_t ev;
    @(negedge clk); start = 1'b1; p0 = cyc + 1;
    @(negedge clk); start = 1'b0;
    total++; if (playing !== 1'b1) begin bad++; $display("FAIL tone_start_playing: got %b want 1", playing); end
    e = p0 + 3 * BEAT + 1 + 250;
    b = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ls = p0 + s * BEAT + ((s == 0) ? 0 : 1);
      le = (s < 3) ? p0 + (s + 1) * BEAT + 1 : e;
      if (b) begin ev_q.push_back('{ls, 1'b0}); b = 1'b0; end
      hp = exp_hp(rom[s]);
      if (hp > 0)
        for (int t = ls + hp; t < le; t += hp) begin b = ~b; ev_q.push_back('{t, b}); end
    end
    if (b) ev_q.push_back('{e, 1'b0});
    lastb = buzzer;
    while (cyc < e + 3) begin
      stop = (cyc == e - 1);
      @(negedge clk);
      if (buzzer !== lastb) begin
        lastb = buzzer;
        total++;
        if (ev_q.size() == 0) begin
          bad++; $display("FAIL tone_extra_edge: got buzzer=%b at cycle %0d, want no edge", buzzer, cyc);
        end else begin
          ev = ev_q.pop_front();
          if (cyc != ev.cyc || buzzer !== ev.v) begin
            bad++;
            $display("FAIL tone_edge: got %b at cycle %0d, want %b at cycle %0d", buzzer, cyc, ev.v, ev.cyc);
          end
        end
      end
    end
    stop = 1'b0;
    total++; if (ev_q.size() != 0) begin bad++; $display("FAIL tone_missing_edges: got %0d pending, want 0", ev_q.size()); ev_q.delete(); end
    total++; if (cnt_music !== 6'd0 || playing !== 1'b0) begin
      bad++; $display("FAIL tone_stop_state: got cnt=%0d play=%b, want cnt=0 play=0", cnt_music, playing);
    end
  endtask

  task automatic test_pause;
    int p0;
    cp_t c;
    @(negedge clk); start = 1'b1; p0 = cyc + 1;
    @(negedge clk); start = 1'b0;
    cp_q.push_back('{p0 + 150, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    cp_q.push_back('{p0 + 151, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    cp_q.push_back('{p0 + 300, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    cp_q.push_back('{p0 + 351, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    cp_q.push_back('{p0 + 425, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    cp_q.push_back('{p0 + 426, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    cp_q.push_back('{p0 + 799, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    cp_q.push_back('{p0 + 800, 6'd1, 1'b1, 1'b1, 1'b1, 1'b0});
    cp_q.push_back('{p0 + 801, 6'd1, 1'b1, 1'b0, 1'b1, 1'b0});
    while (cp_q.size() > 0 && cyc < p0 + 1000) begin
      pause = (cyc >= p0 + 150) && (cyc < p0 + 350);
      @(negedge clk);
      if (cyc == cp_q[0].cyc) begin
        c = cp_q.pop_front();
        total++;
        if (cnt_music !== c.cnt || playing !== c.play || done !== c.dn || (c.chk_buz && buzzer !== c.buz)) begin
          bad++;
          $display("FAIL pause_cp cycle %0d: got cnt=%0d buz=%b play=%b done=%b, want cnt=%0d buz=%b play=%b done=%b",
                   cyc - p0, cnt_music, buzzer, playing, done, c.cnt, c.buz, c.play, c.dn);
        end
      end
    end
    pause = 1'b0;
    total++; if (cp_q.size() != 0) begin bad++; $display("FAIL pause_timeout: got %0d unchecked, want 0", cp_q.size()); cp_q.delete(); end
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic test_back_to_back;
    int p0, t1;
    @(negedge clk); start = 1'b1; p0 = cyc + 1;
    @(negedge clk); start = 1'b0;
    t1 = -1;
    while (cnt_music != 6'd2 && cyc < p0 + 4 * BEAT) begin
      start = (cyc == p0 + 100);
      @(negedge clk);
      if (cnt_music == 6'd1 && t1 < 0) t1 = cyc;
    end
    start = 1'b0;
    total++; if (t1 != p0 + BEAT) begin bad++; $display("FAIL b2b_step_time: got %0d want %0d", t1 - p0, BEAT); end
    total++; if (cnt_music !== 6'd2) begin bad++; $display("FAIL b2b_reach_step2: got %0d want 2", cnt_music); end
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    total++; if (playing !== 1'b0 || cnt_music !== 6'd0 || buzzer !== 1'b0) begin
      bad++; $display("FAIL b2b_all_inputs: got play=%b cnt=%0d buz=%b, want 0 0 0", playing, cnt_music, buzzer);
    end
    repeat (3) @(negedge clk);
    total++; if (playing !== 1'b0) begin bad++; $display("FAIL b2b_stay_idle: got %b want 0", playing); end
  endtask

  task automatic test_async_reset;
    int p0;
    @(negedge clk); start = 1'b1; p0 = cyc + 1;
    @(negedge clk); start = 1'b0;
    while (!(cnt_music == 6'd1 && buzzer == 1'b1) && cyc < p0 + 2 * BEAT) @(negedge clk);
    total++; if (cnt_music !== 6'd1 || buzzer !== 1'b1) begin
      bad++; $display("FAIL areset_setup: got cnt=%0d buz=%b, want cnt=1 buz=1", cnt_music, buzzer);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (buzzer !== 1'b0 || cnt_music !== 6'd0 || playing !== 1'b0) begin
      bad++; $display("FAIL areset_immediate: got buz=%b cnt=%0d play=%b, want 0 0 0", buzzer, cnt_music, playing);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (playing !== 1'b0 || cnt_music !== 6'd0) begin
      bad++; $display("FAIL areset_wait_idle: got play=%b cnt=%0d, want 0 0", playing, cnt_music);
    end
  endtask

  task automatic test_full_play;
    int p0, pulses;
    logic lp;
    cp_t c;
`ifdef MUSIC_LOOP_EN
    lp = 1'b1;
`else
    lp = 1'b0;
`endif
    @(negedge clk); start = 1'b1; p0 = cyc + 1;
    @(negedge clk); start = 1'b0;
    cp_q.push_back('{p0 + 63 * BEAT,     6'd63, 1'b0, 1'b0, 1'b1, 1'b0});
    cp_q.push_back('{p0 + 64 * BEAT - 1, 6'd63, 1'b0, 1'b0, 1'b1, 1'b0});
    cp_q.push_back('{p0 + 64 * BEAT,     6'd0,  ~lp,  1'b0, lp,   1'b1});
    cp_q.push_back('{p0 + 64 * BEAT + 1, 6'd0,  ~lp,  1'b0, lp,   1'b0});
    pulses = 0;
    while (cyc < p0 + 64 * BEAT + 3) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (cp_q.size() > 0 && cyc == cp_q[0].cyc) begin
        c = cp_q.pop_front();
        total++;
        if (cnt_music !== c.cnt || playing !== c.play || done !== c.dn || (c.chk_buz && buzzer !== c.buz)) begin
          bad++;
          $display("FAIL full_cp cycle %0d: got cnt=%0d buz=%b play=%b done=%b, want cnt=%0d buz=%b play=%b done=%b",
                   cyc - p0, cnt_music, buzzer, playing, done, c.cnt, c.buz, c.play, c.dn);
        end
      end
    end
    total++; if (cp_q.size() != 0) begin bad++; $display("FAIL full_timeout: got %0d unchecked, want 0", cp_q.size()); cp_q.delete(); end
    total++; if (pulses != 1) begin bad++; $display("FAIL full_done_pulses: got %0d want 1", pulses); end
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  initial begin
    rom[0] = 8'hDF;
    rom[1] = 8'h7E;
    rom[2] = 8'hFF;
    rom[3] = 8'hFE;
    rom[4] = 8'h7F;
    for (int i = 5; i < 64; i++) rom[i] = fill[i % 16];
    test_reset();
    test_tone();
    test_pause();
    test_back_to_back();
    test_async_reset();
    test_full_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
